sseg_scan_driver: RTL and testbench
===================================

// Module: sseg_scan_driver
// PURPOSE
//  Time-multiplexed N-digit hex seven-segment display driver. Latches a packed nibble word plus per-digit point and blank masks.
//  Scans one digit per slot, decoding its nibble to active-low segments. Drives one-hot active-low anodes with dead-time between slots.
//  Sits between the system datapath and the board display pins; replaces one static decoder per digit.
// PARAMETERS
//  DIGITS        8   number of digits scanned (1..16)
//  SCAN_DIV      16  clk cycles per digit slot (>= BLANK_CYCLES+1)
//  BLANK_CYCLES  2   anti-ghost cycles at slot start with all anodes off (0 = none)
// PORTS
//  clk    in   1          system clock, rising edge
//  rst    in   1          synchronous reset, active-high
//  load   in   1          1: capture data/point/le into shadow regs this edge
//  data   in   4*DIGITS   nibble k = data[4k+3:4k], digit 0 = rightmost
//  point  in   DIGITS     1 = decimal point k lit
//  le     in   DIGITS     1 = digit k blanked (all segs off, point off)
//  seg    out  8          {a,b,c,d,e,f,g,p}, active-low
//  an     out  DIGITS     anode k enable, active-low, at most one low
//  frame  out  1          1-cycle pulse when slot DIGITS-1 ends (index wraps)
// BEHAVIOUR
//  - Reset: shadow data/point/le = 0; prescaler = 0; idx = 0; seg = 8'hFF; an = all 1; frame = 0.
//  - Shadow regs: load=1 -> capture at that edge. Changes are visible from the next slot boundary or the same slot's next cycle.
//    No tearing within a cycle. Load held high captures every cycle.
//  - Prescaler counts 0..SCAN_DIV-1. At SCAN_DIV-1: prescaler -> 0, idx -> idx+1, wrapping DIGITS-1 -> 0.
//    frame=1 on the cycle after the wrap edge only.
//  - seg/an are registered, with 1 cycle latency from idx/prescaler/shadow:
//    prescaler < BLANK_CYCLES (registered view) -> an = all 1, seg = 8'hFF.
//    else an = ~(1<<idx); seg = le[idx] ? 8'hFF : {dec(nib[idx]), ~point[idx]}.
//  - dec() as {a..g}, 0=lit, hex:
//    0:01 1:4F 2:12 3:06 4:4C 5:24 6:20 7:0F 8:00 9:04 A:08 B:60 C:31 D:42 E:30 F:38.
//  - Slot length is exactly SCAN_DIV cycles. Frame period is DIGITS*SCAN_DIV cycles. Lit time per slot is SCAN_DIV-BLANK_CYCLES.
//  - DIGITS=1: idx stays 0; frame pulses every SCAN_DIV cycles.
//  - rst mid-slot: all state returns to reset values on that edge. Display dark the following cycle; scan restarts at digit 0.
//  - rst and load together: rst wins; shadow = 0.
//  - Widths: idx = $clog2(DIGITS) (min 1). Prescaler = $clog2(SCAN_DIV) (min 1). No arithmetic overflow beyond the wrap rules above.
// CONFIGURATION
//  LEADING_ZERO_BLANK_EN defined: blank a digit (segs off, point still honoured) if:
//    (a) its nibble is 0; (b) all higher-index nibbles are 0; (c) it is not digit 0.
//    Blanking is computed from the shadow regs combinationally before the output register, so latency is unchanged.
//  Undefined: all digits are shown per le only; zeros are displayed.
// TESTING  (bench: DIGITS=4, SCAN_DIV=4, BLANK_CYCLES=1)
//  1. Reset held 3 cycles -> seg=FF, an=F, frame=0 throughout. Release -> first lit slot shows digit0 with an=E after BLANK.
//  2. load data=16'h3A7F, point=0 -> slots show an=E seg=71, an=D seg=1F, an=B seg=11, an=7 seg=0D. frame pulse every 16 cycles.
//  3. Cycle 0 of every slot -> an=F, seg=FF (dead-time). Verify no cycle has two an bits low.
//  4. point=4'b0100, le=4'b1000 -> digit2 seg[0]=0; digit3 slot an=7 but seg=FF.
//  5. rst asserted mid-slot of digit2 -> next cycle an=F seg=FF; scan resumes at digit0; shadow=0 -> shows 0 (seg=03).
//  6. LEADING_ZERO_BLANK_EN, data=16'h0050 -> digits3 blank (FF), digit1 seg=49, digit0 seg=03. Undefined -> digit3 seg=03.

Source files
------------

// File: rtl/sseg_scan_driver.sv
// ============================================================================
// sseg_scan_driver -- time-multiplexed N-digit hex seven-segment scan driver
// with registered active-low segments/anodes and per-slot anti-ghost dead-time.
// Optional build macro: LEADING_ZERO_BLANK_EN (suppress leading zero digits).
// Revision: 1.0
// ============================================================================
`default_nettype none

module sseg_scan_driver #(
  parameter int DIGITS       = 8,
  parameter int SCAN_DIV     = 16,
  parameter int BLANK_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   data,
  input  logic [DIGITS-1:0]     point,
  input  logic [DIGITS-1:0]     le,
  output logic [7:0]            seg,
  output logic [DIGITS-1:0]     an,
  output logic                  frame
);

  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int PS_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PS_W-1:0]   c_ps_last  = PS_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0]  c_idx_last = IDX_W'(DIGITS - 1);
  localparam logic [DIGITS-1:0] c_an_one   = DIGITS'(1);

  logic [4*DIGITS-1:0] data_q;
  logic [DIGITS-1:0]   point_q, le_q;
  logic [PS_W-1:0]     ps_q, ps_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [7:0]          seg_q, seg_d;
  logic [DIGITS-1:0]   an_q, an_d;
  logic                frame_q, frame_d;

  logic                w_dark;
  logic [3:0]          w_nib;
  logic [DIGITS-1:0]   w_lz;

  function automatic logic [6:0] dec(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'h01;  4'h1: s = 7'h4F;  4'h2: s = 7'h12;  4'h3: s = 7'h06;
      4'h4: s = 7'h4C;  4'h5: s = 7'h24;  4'h6: s = 7'h20;  4'h7: s = 7'h0F;
      4'h8: s = 7'h00;  4'h9: s = 7'h04;  4'hA: s = 7'h08;  4'hB: s = 7'h60;
      4'hC: s = 7'h31;  4'hD: s = 7'h42;  4'hE: s = 7'h30;  default: s = 7'h38;
    endcase
    return s;
  endfunction

  // Dead-time window is judged on the registered prescaler value.
  if (BLANK_CYCLES == 0) begin : g_no_dark
    assign w_dark = 1'b0;
  end else begin : g_dark
    localparam logic [PS_W-1:0] c_blank = PS_W'(BLANK_CYCLES);
    assign w_dark = (ps_q < c_blank);
  end

  assign w_nib = data_q[{idx_q, 2'b00} +: 4];

`ifdef LEADING_ZERO_BLANK_EN
  // Walk from the top digit down; a digit is suppressed only while every
  // nibble at or above it is zero. Digit 0 is never suppressed.
  always_comb begin
    logic hi_zero;
    hi_zero = 1'b1;
    w_lz    = '0;
    for (int k = DIGITS - 1; k >= 1; k--) begin
      hi_zero = hi_zero & (data_q[4*k +: 4] == 4'h0);
      w_lz[k] = hi_zero;
    end
  end
`else
  assign w_lz = '0;
`endif

  always_comb begin
    ps_d    = ps_q + PS_W'(1);
    idx_d   = idx_q;
    frame_d = 1'b0;
    if (ps_q == c_ps_last) begin
      ps_d    = '0;
      idx_d   = (idx_q == c_idx_last) ? '0 : idx_q + IDX_W'(1);
      frame_d = (idx_q == c_idx_last);
    end
  end

  always_comb begin
    an_d  = '1;
    seg_d = 8'hFF;
    if (!w_dark) begin
      an_d = ~(c_an_one << idx_q);
      if (!le_q[idx_q]) begin
        seg_d = {(w_lz[idx_q] ? 7'h7F : dec(w_nib)), ~point_q[idx_q]};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q  <= '0;
      point_q <= '0;
      le_q    <= '0;
      ps_q    <= '0;
      idx_q   <= '0;
      seg_q   <= 8'hFF;
      an_q    <= '1;
      frame_q <= 1'b0;
    end else begin
      if (load) begin
        data_q  <= data;
        point_q <= point;
        le_q    <= le;
      end
      ps_q    <= ps_d;
      idx_q   <= idx_d;
      seg_q   <= seg_d;
      an_q    <= an_d;
      frame_q <= frame_d;
    end
  end

  assign seg   = seg_q;
  assign an    = an_q;
  assign frame = frame_q;

endmodule

`default_nettype wire

// File: tb/tb_sseg_scan_driver.sv
// ============================================================================
// tb_sseg_scan_driver -- self-checking bench, DIGITS=4 SCAN_DIV=4 BLANK=1.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_sseg_scan_driver;

  localparam int DIGITS = 4;
  localparam int SCAN_DIV = 4;
  localparam int BLANK_CYCLES = 1;
`ifdef LEADING_ZERO_BLANK_EN
  localparam bit LZB = 1'b1;
`else
  localparam bit LZB = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load = 1'b0;
  logic [15:0] data = '0;
  logic [3:0]  point = '0;
  logic [3:0]  le = '0;
  logic [7:0]  seg;
  logic [3:0]  an;
  logic        frame;

  sseg_scan_driver #(.DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV), .BLANK_CYCLES(BLANK_CYCLES)) dut (
    .clk(clk), .rst(rst), .load(load), .data(data), .point(point), .le(le),
    .seg(seg), .an(an), .frame(frame)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] seg;
    logic [3:0] an;
    logic       frame;
  } exp_t;

  typedef struct {
    logic [15:0]     d;
    logic [3:0]      p;
    logic [3:0]      l;
    logic [3:0][7:0] s;
  } vec_t;

  logic [6:0] dec_tab [16] = '{7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
                               7'h00, 7'h04, 7'h08, 7'h60, 7'h31, 7'h42, 7'h30, 7'h38};

  exp_t sb[$];
  vec_t vecs [8];

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int last_frame = -1;

  // Reference model state
  int          m_ps = 0;
  int          m_idx = 0;
  logic [15:0] m_data = '0;
  logic [3:0]  m_pt = '0;
  logic [3:0]  m_le = '0;

  logic [15:0] cur_d = '0;
  logic [3:0]  cur_p = '0;
  logic [3:0]  cur_l = '0;
  bit          tbl_en = 1'b0;
  logic [3:0][7:0] tbl_s = '0;

  function automatic exp_t model_out();
    exp_t e;
    logic [3:0] nib;
    logic [6:0] s7;
    bit hz;
    e.frame = (m_ps == SCAN_DIV - 1) && (m_idx == DIGITS - 1);
    if (m_ps < BLANK_CYCLES) begin
      e.seg = 8'hFF;
      e.an  = 4'hF;
    end else begin
      e.an = 4'hF;
      e.an[m_idx] = 1'b0;
      nib = m_data[m_idx*4 +: 4];
      if (m_le[m_idx]) begin
        e.seg = 8'hFF;
      end else begin
        s7 = dec_tab[nib];
        hz = 1'b1;
        for (int j = m_idx; j < DIGITS; j++) if (m_data[j*4 +: 4] != 4'h0) hz = 1'b0;
        if (LZB && m_idx != 0 && hz) s7 = 7'h7F;
        e.seg = {s7, ~m_pt[m_idx]};
      end
    end
    return e;
  endfunction

  task automatic step(input logic r, input logic ld);
    exp_t e, got;
    @(negedge clk);
    rst = r; load = ld; data = cur_d; point = cur_p; le = cur_l;
    if (r) e = '{seg: 8'hFF, an: 4'hF, frame: 1'b0};
    else   e = model_out();
    sb.push_back(e);
    if (r) begin
      m_ps = 0; m_idx = 0; m_data = '0; m_pt = '0; m_le = '0;
    end else begin
      if (ld) begin m_data = cur_d; m_pt = cur_p; m_le = cur_l; end
      if (m_ps == SCAN_DIV - 1) begin
        m_ps = 0;
        m_idx = (m_idx == DIGITS - 1) ? 0 : m_idx + 1;
      end else begin
        m_ps++;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    got = '{seg: seg, an: an, frame: frame};
    e = sb.pop_front();
    checks++;
    if (got !== e) begin
      errors++;
      $display("FAIL scoreboard cyc=%0d: got seg=%h an=%h frame=%b, expected seg=%h an=%h frame=%b",
               cyc, got.seg, got.an, got.frame, e.seg, e.an, e.frame);
    end
    checks++;
    if ($countones(~an) > 1) begin
      errors++;
      $display("FAIL anode_onehot cyc=%0d: got an=%b, expected at most one low bit", cyc, an);
    end
    if (tbl_en && an != 4'hF) begin
      for (int k = 0; k < DIGITS; k++) begin
        if (an == ~(4'b0001 << k)) begin
          checks++;
          if (seg !== tbl_s[k]) begin
            errors++;
            $display("FAIL table_digit%0d cyc=%0d: got seg=%h, expected %h", k, cyc, seg, tbl_s[k]);
          end
        end
      end
    end
    if (r) last_frame = -1;
    else if (frame === 1'b1) begin
      if (last_frame >= 0) begin
        checks++;
        if (cyc - last_frame != DIGITS * SCAN_DIV) begin
          errors++;
          $display("FAIL frame_period: got %0d cycles, expected %0d", cyc - last_frame, DIGITS * SCAN_DIV);
        end
      end
      last_frame = cyc;
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0);
  endtask

  task automatic check_out(input string name, input logic [7:0] s, input logic [3:0] a);
    checks++;
    if (seg !== s || an !== a) begin
      errors++;
      $display("FAIL %s: got seg=%h an=%h, expected seg=%h an=%h", name, seg, an, s, a);
    end
  endtask

  initial begin
    vecs[0] = '{16'h3A7F, 4'h0, 4'h0, {8'h0D, 8'h11, 8'h1F, 8'h71}};
    vecs[1] = '{16'h3A7F, 4'h4, 4'h8, {8'hFF, 8'h10, 8'h1F, 8'h71}};
    vecs[2] = '{16'h0050, 4'h0, 4'h0, {(LZB ? 8'hFF : 8'h03), (LZB ? 8'hFF : 8'h03), 8'h49, 8'h03}};
    vecs[3] = '{16'h8421, 4'hF, 4'h0, {8'h00, 8'h98, 8'h24, 8'h9E}};
    vecs[4] = '{16'hFEDC, 4'h1, 4'h2, {8'h71, 8'h61, 8'hFF, 8'h62}};
    vecs[5] = '{16'h9650, 4'h0, 4'h5, {8'h09, 8'hFF, 8'h49, 8'hFF}};
    vecs[6] = '{16'h0B00, 4'h2, 4'h0, {(LZB ? 8'hFF : 8'h03), 8'hC1, 8'h02, 8'h03}};
    vecs[7] = '{16'h0000, 4'h8, 4'h0, {(LZB ? 8'hFE : 8'h02), (LZB ? 8'hFF : 8'h03),
                                       (LZB ? 8'hFF : 8'h03), 8'h03}};

    // Reset held three cycles, then release: first lit slot is digit 0 showing 0.
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0);
      check_out("reset_hold", 8'hFF, 4'hF);
    end
    step(1'b0, 1'b0);
    check_out("release_dark", 8'hFF, 4'hF);
    step(1'b0, 1'b0);
    check_out("first_lit_digit0", 8'h03, 4'hE);
    run(20);

    // Table of shadow patterns, each observed over a full frame.
    for (int v = 0; v < 8; v++) begin
      cur_d = vecs[v].d; cur_p = vecs[v].p; cur_l = vecs[v].l;
      step(1'b0, 1'b1);
      step(1'b0, 1'b0);
      tbl_s = vecs[v].s;
      tbl_en = 1'b1;
      run(DIGITS * SCAN_DIV + 2);
      tbl_en = 1'b0;
    end

    // Load held high for several cycles with changing data.
    for (int i = 0; i < 6; i++) begin
      cur_d = 16'h1111 * i[15:0];
      step(1'b0, 1'b1);
    end
    run(4);

    // Reset mid-slot of digit 2.
    cur_d = 16'h3A7F; cur_p = 4'h0; cur_l = 4'h0;
    step(1'b0, 1'b1);
    begin
      int guard = 0;
      while (!(m_idx == 2 && m_ps == 2) && guard < 40) begin
        step(1'b0, 1'b0);
        guard++;
      end
      checks++;
      if (guard >= 40) begin
        errors++;
        $display("FAIL midslot_wait: got timeout after %0d cycles, expected digit2 mid-slot", guard);
      end
    end
    step(1'b1, 1'b0);
    check_out("midslot_reset_dark", 8'hFF, 4'hF);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    check_out("after_reset_digit0", 8'h03, 4'hE);
    run(6);

    // Reset and load together: reset wins, shadow stays zero.
    cur_d = 16'h1234; cur_p = 4'hF;
    step(1'b1, 1'b1);
    check_out("rst_load_dark", 8'hFF, 4'hF);
    cur_p = 4'h0;
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    check_out("rst_load_shadow_zero", 8'h03, 4'hE);
    run(DIGITS * SCAN_DIV * 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
